// File: rtl/pcs_rx_2_fifo_interface_pkg.sv
// Shared types and constants for the PCS RX to FIFO interface: FSM encoding,
// frame-length limits, counter/length widths and a saturating increment.
package pcs_rx_2_fifo_interface_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam int LEN_W           = 15;
  localparam int CNT_W           = 16;
  localparam int USEDW_W         = 12;
  localparam int FREE_W          = 13;
  localparam int FREE_EXT_W      = FREE_W + 1;
  localparam int FIFO_DEPTH_C    = 4096;
  localparam int MIN_FRAME_LEN_C = 16;
  localparam int MAX_FRAME_LEN_C = 1024;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pcs_rx_2_fifo_interface_if.sv
// ARI receive handshake plus RX FIFO write port. master = frame source / FIFO
// side, slave = the pcs_rx_2_fifo_interface block.
interface pcs_rx_2_fifo_interface_if;
  import pcs_rx_2_fifo_interface_pkg::*;

  logic               i_ari_val;
  logic               i_ari_sof;
  logic               i_ari_eof;
  logic [7:0]         i_ari_data;
  logic [LEN_W-1:0]   i_ari_frame_len;
  logic               i_ari_frame_len_val;
  logic               o_ari_ack;
  logic               o_fifo_wr_en;
  logic [7:0]         o_fifo_wr_data;
  logic               i_fifo_wr_full;
  logic [USEDW_W-1:0] i_fifo_wrusedw;

  modport master (
    output i_ari_val, i_ari_sof, i_ari_eof, i_ari_data, i_ari_frame_len,
           i_ari_frame_len_val, i_fifo_wr_full, i_fifo_wrusedw,
    input  o_ari_ack, o_fifo_wr_en, o_fifo_wr_data
  );

  modport slave (
    input  i_ari_val, i_ari_sof, i_ari_eof, i_ari_data, i_ari_frame_len,
           i_ari_frame_len_val, i_fifo_wr_full, i_fifo_wrusedw,
    output o_ari_ack, o_fifo_wr_en, o_fifo_wr_data
  );

endinterface

// File: rtl/pcs_rx_2_fifo_interface_rx_frame_checker.sv
// Per-frame beat counter and latched length; reports length match, max-length
// hit and the first suppressed (FIFO full) write of the frame.
module pcs_rx_2_fifo_interface_rx_frame_checker
  import pcs_rx_2_fifo_interface_pkg::*;
#(
  parameter int MAX_FRAME_LEN = MAX_FRAME_LEN_C
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_beat,
  input  logic             i_blocked,
  input  logic [LEN_W-1:0] i_frame_len,
  output logic [LEN_W-1:0] o_cnt_nxt,
  output logic             o_at_max,
  output logic             o_end_ok,
  output logic             o_full_err
);

  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             flag_q, flag_d;

  assign o_cnt_nxt = cnt_q + LEN_W'(1);
  assign o_at_max  = (o_cnt_nxt == LEN_W'(MAX_FRAME_LEN));
  // A frame that lost any byte to a full FIFO can never end good.
  assign o_end_ok  = (o_cnt_nxt == len_q) && !flag_q && !i_blocked;

  always_comb begin
    cnt_d      = cnt_q;
    len_d      = len_q;
    flag_d     = flag_q;
    o_full_err = 1'b0;
    if (i_start) begin
      cnt_d      = LEN_W'(1);
      len_d      = i_frame_len;
      flag_d     = i_blocked;
      o_full_err = i_blocked;
    end else if (i_beat) begin
      cnt_d      = o_cnt_nxt;
      flag_d     = flag_q | i_blocked;
      o_full_err = i_blocked && !flag_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q  <= '0;
      len_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      flag_q <= flag_d;
    end
  end

endmodule

// File: rtl/pcs_rx_2_fifo_interface.sv
// Receives ARI byte frames, admits them against length limits and reserved
// FIFO space, writes payload to the RX FIFO and reports/counts outcomes.
module pcs_rx_2_fifo_interface
  import pcs_rx_2_fifo_interface_pkg::*;
#(
  parameter int FIFO_DEPTH    = FIFO_DEPTH_C,
  parameter int MAX_FRAME_LEN = MAX_FRAME_LEN_C,
  parameter int MIN_FRAME_LEN = MIN_FRAME_LEN_C
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  pcs_rx_2_fifo_interface_if.slave ari,
  output logic                    o_frame_ok,
  output logic                    o_frame_err,
  output logic                    o_frame_drop,
  output logic [LEN_W-1:0]        o_last_frame_len,
  output logic [CNT_W-1:0]        o_frame_cnt,
  output logic [CNT_W-1:0]        o_err_cnt
);

  state_e           state_q, state_d;
  logic             wr_en_q, wr_en_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             ok_q, ok_d, err_q, err_d, drop_q, drop_d;
  logic [LEN_W-1:0] last_len_q, last_len_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;

  logic [FREE_W:0]   free_raw;
  logic [FREE_W-1:0] free_space;
  logic              sof_beat, sof_accept, chk_start, chk_beat, wr_try, blocked;
  logic [LEN_W-1:0]  cnt_nxt;
  logic              at_max, end_ok, full_err;

  assign ari.o_ari_ack = ari.i_ari_val;

  // The write still in flight counts against free space so back-to-back frames stay safe.
  assign free_raw   = FREE_EXT_W'(FIFO_DEPTH - 1) - FREE_EXT_W'(ari.i_fifo_wrusedw)
                    - FREE_EXT_W'(wr_en_q);
  assign free_space = free_raw[FREE_W] ? '0 : free_raw[FREE_W-1:0];
  assign sof_accept = ari.i_ari_frame_len_val
                    && (ari.i_ari_frame_len >= LEN_W'(MIN_FRAME_LEN))
                    && (ari.i_ari_frame_len <= LEN_W'(MAX_FRAME_LEN))
                    && (LEN_W'(free_space) >= ari.i_ari_frame_len);

  // SOF is honoured in IDLE and DATA (abort + restart); DROP ignores it until EOF.
  assign sof_beat  = ari.i_ari_val && ari.i_ari_sof && (state_q != ST_DROP);
  assign chk_start = sof_beat && sof_accept;
  assign chk_beat  = ari.i_ari_val && !ari.i_ari_sof && (state_q == ST_DATA);
  assign wr_try    = chk_start || chk_beat;
  assign blocked   = wr_try && ari.i_fifo_wr_full;

  pcs_rx_2_fifo_interface_rx_frame_checker #(
    .MAX_FRAME_LEN (MAX_FRAME_LEN)
  ) u_checker (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (chk_start),
    .i_beat      (chk_beat),
    .i_blocked   (blocked),
    .i_frame_len (ari.i_ari_frame_len),
    .o_cnt_nxt   (cnt_nxt),
    .o_at_max    (at_max),
    .o_end_ok    (end_ok),
    .o_full_err  (full_err)
  );

  always_comb begin
    state_d    = state_q;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    drop_d     = 1'b0;
    last_len_d = last_len_q;
    wr_en_d    = wr_try && !ari.i_fifo_wr_full;
    wr_data_d  = wr_try ? ari.i_ari_data : wr_data_q;

    unique case (state_q)
      ST_IDLE: begin
      end
      ST_DATA: begin
        if (chk_beat) begin
          if (ari.i_ari_eof) begin
            ok_d       = end_ok;
            err_d      = !end_ok;
            last_len_d = cnt_nxt;
            state_d    = ST_IDLE;
          end else if (at_max) begin
            err_d   = 1'b1;
            state_d = ST_DROP;
          end
        end else if (sof_beat) begin
          err_d = 1'b1;
        end
      end
      ST_DROP: begin
        if (ari.i_ari_val && ari.i_ari_eof) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (sof_beat) begin
      if (chk_start) begin
        state_d = ari.i_ari_eof ? ST_IDLE : ST_DATA;
        if (ari.i_ari_eof) begin
          err_d      = 1'b1;
          last_len_d = LEN_W'(1);
        end
      end else begin
        drop_d  = 1'b1;
        state_d = ari.i_ari_eof ? ST_IDLE : ST_DROP;
      end
    end

    if (full_err) err_d = 1'b1;

    frame_cnt_d = ok_d ? sat_inc(frame_cnt_q) : frame_cnt_q;
    err_cnt_d   = (err_d || drop_d) ? sat_inc(err_cnt_q) : err_cnt_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
      last_len_q  <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
      last_len_q  <= last_len_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign ari.o_fifo_wr_en   = wr_en_q;
  assign ari.o_fifo_wr_data = wr_data_q;
  assign o_frame_ok         = ok_q;
  assign o_frame_err        = err_q;
  assign o_frame_drop       = drop_q;
  assign o_last_frame_len   = last_len_q;
  assign o_frame_cnt        = frame_cnt_q;
  assign o_err_cnt          = err_cnt_q;

endmodule

// File: doc/pcs_rx_2_fifo_interface.md
# pcs_rx_2_fifo_interface

Receive-side counterpart of the FIFO-to-PCS transmit interface. It accepts byte frames from pcs_rx over the ARI handshake (val/sof/eof/data with ack) and writes the payload bytes into the RX FIFO. Before accepting a frame it checks the announced frame length and the free FIFO space. It flags length and framing errors, discards frames that cannot be stored, and keeps frame and error counters.

## Interface
- FIFO_DEPTH, 4096: RX FIFO depth in bytes.
- MAX_FRAME_LEN, 1024: largest legal frame length in bytes.
- MIN_FRAME_LEN, 16: smallest legal frame length in bytes.
- i_clk  in  1  single clock for the whole block.
- i_rst  in  1  reset; asynchronous and active-high.
- i_ari_val  in  1  beat valid.
- i_ari_sof  in  1  first beat of a frame.
- i_ari_eof  in  1  last beat of a frame.
- i_ari_data  in  8  beat byte.
- i_ari_frame_len  in  15  announced frame length.
- i_ari_frame_len_val  in  1  frame length is valid.
- o_ari_ack  out  1  beat accepted; a transfer is val&&ack in the same cycle.
- o_fifo_wr_en  out  1  FIFO write strobe.
- o_fifo_wr_data  out  8  FIFO write byte.
- i_fifo_wr_full  in  1  FIFO full.
- i_fifo_wrusedw  in  12  FIFO fill level (write side).
- o_frame_ok  out  1  pulse: frame completed with correct length.
- o_frame_err  out  1  pulse: length, framing or overflow error.
- o_frame_drop  out  1  pulse: frame rejected at its SOF.
- o_last_frame_len  out  15  byte count of the last completed frame (ok or err).
- o_frame_cnt  out  16  count of good frames; saturates.
- o_err_cnt  out  16  count of err plus drop events; saturates.

## Operation
- States: IDLE, DATA, DROP. Reset to IDLE; every output and counter resets to 0.
- o_ari_ack = i_ari_val in every state. The block never back-pressures; FIFO space is reserved at SOF.
- Free space = FIFO_DEPTH-1-i_fifo_wrusedw-o_fifo_wr_en, computed at 13 bits, unsigned, never negative.
- IDLE:
  - val&&sof: latch len. Accept if frame_len_val is high, MIN_FRAME_LEN≤len≤MAX_FRAME_LEN and free space≥len. On accept, write the byte, set beat count to 1 and go to DATA.
  - Otherwise pulse o_frame_drop and go to DROP.
  - If eof arrives on the same beat, stay in IDLE: an accepted frame gets o_frame_err, a dropped frame gets drop only.
  - val without sof (stray beat): ack and discard with no pulse.
- DATA, every val beat writes and increments the count:
  - eof: if count equals len, pulse o_frame_ok; else pulse o_frame_err. Update o_last_frame_len and go to IDLE.
  - count reaches MAX_FRAME_LEN without eof: pulse o_frame_err and go to DROP.
  - sof in DATA: abort the current frame with o_frame_err, then evaluate the beat as a fresh SOF under the IDLE rules in the same cycle.
- DROP: ack and discard; eof returns to IDLE.
- A write issued while i_fifo_wr_full is high is suppressed and pulses o_frame_err once per frame. The frame still finishes in DATA but ends with err, not ok.
- Counters saturate at 0xFFFF. An err pulse and a drop pulse in the same cycle increment o_err_cnt by 1.

## Timing
- o_ari_ack is combinational from i_ari_val.
- o_fifo_wr_en/o_fifo_wr_data are registered, one cycle after the accepted beat.
- o_frame_ok, o_frame_err, o_frame_drop, o_last_frame_len and the counters are registered and update one cycle after the deciding beat.
- Back-to-back frames are allowed: an eof beat followed by a sof beat on the next cycle loses no data.
- Reset mid-frame returns to IDLE immediately and cancels any pending write. The remaining beats of that frame are treated as stray and discarded.

## Structure
- Shared package: state encoding (IDLE/DATA/DROP), MIN/MAX frame-length constants, counter width, ARI length width (15).
- One natural sub-module: rx_frame_checker (beat counter, length compare, ok/err decision); the FSM, FIFO write register and counters sit in the top.

## Test plan
- 16-byte frame 0x00..0x0F, len=16, FIFO empty -> 16 writes in order, one o_frame_ok, o_frame_cnt=1, o_last_frame_len=16.
- len=20, eof on beat 18 -> 18 writes, o_frame_err, o_last_frame_len=18, o_err_cnt=1.
- wrusedw=3500, len=1024 -> o_frame_drop at SOF, zero writes, all 1024 beats acked, back to IDLE after eof.
- len=8 (below MIN), or frame_len_val=0 -> drop, no writes; next valid 32-byte frame -> ok.
- sof re-asserted at beat 10 of a 64-byte frame -> o_frame_err, new frame accepted from that beat; completes ok with 64 further beats.
- i_rst pulsed at beat 5 of 100 -> outputs 0, remaining 95 beats acked with no writes; next frame -> ok.
